// File: rtl/fas_pkg.sv
// Shared types and sizes for the FAS analysis blocks.
package fas_pkg;
    localparam int NBINS = 16;
    localparam int DW    = 16;
    localparam int MAGW  = 2*DW + 1;
    localparam int BW    = $clog2(NBINS);

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } cplx_t;

    typedef logic [MAGW-1:0] mag_t;

    typedef enum logic [1:0] {IDLE, CALC, FLUSH, DONE} state_t;
endpackage

// File: rtl/fas_mag_sq.sv
// Registered magnitude-squared of one complex sample: re*re + im*im, full precision.
module fas_mag_sq
    import fas_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  in_valid_i,
    input  cplx_t x_i,
    output logic  valid_o,
    output mag_t  sq_o
);

    logic signed [2*DW-1:0] re_ext, im_ext, re2, im2;
    mag_t                   sq_d, sq_q;
    logic                   valid_q;

    // Squares are non-negative, but -32768^2 lands exactly on 2^30, so keep the sign bit on extension.
    always_comb begin
        re_ext = {{DW{x_i.re[DW-1]}}, x_i.re};
        im_ext = {{DW{x_i.im[DW-1]}}, x_i.im};
        re2    = re_ext * re_ext;
        im2    = im_ext * im_ext;
        sq_d   = mag_t'({re2[2*DW-1], re2}) + mag_t'({im2[2*DW-1], im2});
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            sq_q    <= '0;
        end else begin
            valid_q <= in_valid_i;
            sq_q    <= sq_d;
        end
    end

    assign valid_o = valid_q;
    assign sq_o    = sq_q;

endmodule

// File: rtl/fas_freq_analyzer.sv
// Peak-bin finder for 16-bin FFT frames, with one pending-frame buffer.
//  state | meaning
//  IDLE  | no frame in work; waiting for fft_valid or a pending frame
//  CALC  | issuing bins 0..15 into the magnitude pipeline
//  FLUSH | two cycles draining the square and compare stages
//  DONE  | publish freq/peak_mag; promote pending frame if present
module fas_freq_analyzer
    import fas_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            fft_valid,
    input  logic [31:0]     fft_d0,  fft_d1,  fft_d2,  fft_d3,
    input  logic [31:0]     fft_d4,  fft_d5,  fft_d6,  fft_d7,
    input  logic [31:0]     fft_d8,  fft_d9,  fft_d10, fft_d11,
    input  logic [31:0]     fft_d12, fft_d13, fft_d14, fft_d15,
    output logic            done,
    output logic [BW-1:0]   freq,
    output logic [MAGW-1:0] peak_mag,
    output logic            overflow
);

    state_t        state_q, state_d;
    cplx_t         frame_in [NBINS];
    cplx_t         work_q   [NBINS];
    cplx_t         pend_q   [NBINS];
    logic          pend_full_q, pend_full_d;
    logic [BW-1:0] bin_q, bin_d, s1_bin_q;
    logic          flush_q;
    logic          take_work, take_pend, promote, drop, issue, done_d;
    logic          s1_valid;
    mag_t          s1_sq, max_q;
    logic [BW-1:0] max_idx_q, freq_q;
    mag_t          peak_q;
    logic          done_q, ovf_q;

    always_comb begin
        frame_in[0]  = cplx_t'(fft_d0);  frame_in[1]  = cplx_t'(fft_d1);
        frame_in[2]  = cplx_t'(fft_d2);  frame_in[3]  = cplx_t'(fft_d3);
        frame_in[4]  = cplx_t'(fft_d4);  frame_in[5]  = cplx_t'(fft_d5);
        frame_in[6]  = cplx_t'(fft_d6);  frame_in[7]  = cplx_t'(fft_d7);
        frame_in[8]  = cplx_t'(fft_d8);  frame_in[9]  = cplx_t'(fft_d9);
        frame_in[10] = cplx_t'(fft_d10); frame_in[11] = cplx_t'(fft_d11);
        frame_in[12] = cplx_t'(fft_d12); frame_in[13] = cplx_t'(fft_d13);
        frame_in[14] = cplx_t'(fft_d14); frame_in[15] = cplx_t'(fft_d15);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // IDLE also promotes: a frame that landed in pending during a DONE->IDLE cycle must not stall.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pend_full_q || fft_valid) state_d = CALC;
            CALC:    if (bin_q == BW'(NBINS-1))    state_d = FLUSH;
            FLUSH:   if (flush_q)                  state_d = DONE;
            DONE:    state_d = pend_full_q ? CALC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        promote     = pend_full_q && (state_q == IDLE || state_q == DONE);
        take_work   = fft_valid && (state_q == IDLE) && !pend_full_q;
        take_pend   = fft_valid && !take_work && (!pend_full_q || promote);
        drop        = fft_valid && !take_work && !take_pend;
        issue       = (state_q == CALC);
        done_d      = (state_q == DONE);
        bin_d       = issue ? bin_q + BW'(1) : '0;
        pend_full_d = take_pend ? 1'b1 : (promote ? 1'b0 : pend_full_q);
    end

    always_ff @(posedge clk) begin
        if (take_work)    work_q <= frame_in;
        else if (promote) work_q <= pend_q;
        if (take_pend)    pend_q <= frame_in;
    end

    fas_mag_sq u_mag_sq (
        .clk        (clk),
        .rst        (rst),
        .in_valid_i (issue),
        .x_i        (work_q[bin_q]),
        .valid_o    (s1_valid),
        .sq_o       (s1_sq)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_full_q <= 1'b0;
            bin_q       <= '0;
            s1_bin_q    <= '0;
            flush_q     <= 1'b0;
            max_q       <= '0;
            max_idx_q   <= '0;
            done_q      <= 1'b0;
            freq_q      <= '0;
            peak_q      <= '0;
            ovf_q       <= 1'b0;
        end else begin
            pend_full_q <= pend_full_d;
            bin_q       <= bin_d;
            s1_bin_q    <= bin_q;
            flush_q     <= (state_q == FLUSH) && !flush_q;
            // Bin 0 seeds the max; strict compare keeps the lowest index on ties.
            if (s1_valid && (s1_bin_q == '0 || s1_sq > max_q)) begin
                max_q     <= s1_sq;
                max_idx_q <= s1_bin_q;
            end
            done_q <= done_d;
            if (done_d) begin
                freq_q <= max_idx_q;
                peak_q <= max_q;
            end
            if (drop) ovf_q <= 1'b1;
        end
    end

    assign done     = done_q;
    assign freq     = freq_q;
    assign peak_mag = peak_q;
    assign overflow = ovf_q;

endmodule
